// File: rtl/router_reg.sv
// Router datapath register stage: captures the header, buffers the byte that
// arrives as the FIFO fills, drives the FIFO write data and tracks packet parity.
module router_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic             parity_done,
    output logic             low_packet_valid,
    output logic             err,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] hdr;
    logic [WIDTH-1:0] full_byte;
    logic [WIDTH-1:0] int_parity;
    logic [WIDTH-1:0] pkt_parity;

    // Address 2'b11 names no output port, so such a header is not latched.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            hdr <= '0;
        else if (detect_add && pkt_valid && (data_in[1:0] != 2'b11))
            hdr <= data_in;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            dout <= '0;
        else if (lfd_state)
            dout <= hdr;
        else if (ld_state && !fifo_full)
            dout <= data_in;
        else if (laf_state)
            dout <= full_byte;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            full_byte <= '0;
        else if (ld_state && fifo_full)
            full_byte <= data_in;
    end

    // A byte diverted to full_byte is still part of the payload parity.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            int_parity <= '0;
        else if (detect_add)
            int_parity <= '0;
        else if (lfd_state)
            int_parity <= int_parity ^ hdr;
        else if (ld_state && pkt_valid && !full_state)
            int_parity <= int_parity ^ data_in;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            pkt_parity <= '0;
        else if (detect_add)
            pkt_parity <= '0;
        else if (ld_state && !pkt_valid)
            pkt_parity <= data_in;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            parity_done <= 1'b0;
        else if (detect_add)
            parity_done <= 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_packet_valid && !parity_done))
            parity_done <= 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            low_packet_valid <= 1'b0;
        else if (rst_int_reg)
            low_packet_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            low_packet_valid <= 1'b1;
    end

    // Compares one clock after parity_done so both parity registers are settled.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            err <= 1'b0;
        else if (detect_add)
            err <= 1'b0;
        else if (parity_done && (int_parity != pkt_parity))
            err <= 1'b1;
    end

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: drives FSM strobes cycle by cycle and checks
// dout, parity flags and error against hand-computed values.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       parity_done, low_packet_valid, err;
    logic [7:0] dout;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] DA   = 6'b100000;
    localparam logic [5:0] LFD  = 6'b010000;
    localparam logic [5:0] LD   = 6'b001000;
    localparam logic [5:0] LAF  = 6'b000100;
    localparam logic [5:0] FS   = 6'b000010;
    localparam logic [5:0] RIR  = 6'b000001;

    router_reg #(.WIDTH(8)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err),
        .dout             (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes and data, then settle just after the edge.
    task automatic step(input logic [5:0] st, input logic pv, input logic ff,
                        input logic [7:0] d);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        pkt_valid = pv;
        fifo_full = ff;
        data_in   = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = IDLE;
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        data_in   = 8'h00;
        #12;
        chk("rst_dout", dout, 8'h00);
        chk("rst_pd", {7'b0, parity_done}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        chk("rst_lpv", {7'b0, low_packet_valid}, 8'h00);
        resetn = 1'b1;

        // Good packet, no full
        step(DA,  1, 0, 8'h0C);
        step(LFD, 1, 0, 8'h11);  chk("good_hdr", dout, 8'h0C);
        step(LD,  1, 0, 8'h11);  chk("good_d0", dout, 8'h11);
        step(LD,  1, 0, 8'h22);  chk("good_d1", dout, 8'h22);
        step(LD,  1, 0, 8'h33);  chk("good_d2", dout, 8'h33);
        chk("good_pd_early", {7'b0, parity_done}, 8'h00);
        step(LD,  0, 0, 8'h0C);  chk("good_par", dout, 8'h0C);
        chk("good_pd", {7'b0, parity_done}, 8'h01);
        chk("good_lpv", {7'b0, low_packet_valid}, 8'h01);
        step(RIR, 0, 0, 8'h00);
        chk("good_err", {7'b0, err}, 8'h00);
        chk("good_lpv_clr", {7'b0, low_packet_valid}, 8'h00);
        chk("good_hold", dout, 8'h0C);

        // Bad parity
        step(DA,  1, 0, 8'h0C);  chk("bad_pd_clr", {7'b0, parity_done}, 8'h00);
        step(LFD, 1, 0, 8'h11);
        step(LD,  1, 0, 8'h11);
        step(LD,  1, 0, 8'h22);
        step(LD,  1, 0, 8'h33);
        step(LD,  0, 0, 8'hFF);  chk("bad_par", dout, 8'hFF);
        chk("bad_pd", {7'b0, parity_done}, 8'h01);
        chk("bad_err_notyet", {7'b0, err}, 8'h00);
        step(RIR, 0, 0, 8'h00);  chk("bad_err", {7'b0, err}, 8'h01);
        step(IDLE, 0, 0, 8'h00); chk("bad_err_sticky", {7'b0, err}, 8'h01);

        // FIFO full mid-packet; detect_add here also clears err
        step(DA,  1, 0, 8'h0C);  chk("full_err_clr", {7'b0, err}, 8'h00);
        step(LFD, 1, 0, 8'h11);  chk("full_hdr", dout, 8'h0C);
        step(LD,  1, 0, 8'h11);  chk("full_d0", dout, 8'h11);
        step(LD,  1, 1, 8'h22);  chk("full_hold", dout, 8'h11);
        step(FS,  1, 1, 8'h22);  chk("full_state_hold", dout, 8'h11);
        step(LAF, 1, 0, 8'h22);  chk("full_laf", dout, 8'h22);
        chk("full_laf_pd", {7'b0, parity_done}, 8'h00);
        step(LD,  1, 0, 8'h33);  chk("full_d2", dout, 8'h33);
        step(LD,  0, 0, 8'h0C);  chk("full_pd", {7'b0, parity_done}, 8'h01);
        chk("full_intpar", dut.int_parity, 8'h0C);
        step(RIR, 0, 0, 8'h00);  chk("full_err", {7'b0, err}, 8'h00);

        // FIFO full on the parity byte
        step(DA,  1, 0, 8'h0C);
        step(LFD, 1, 0, 8'h11);
        step(LD,  1, 0, 8'h11);
        step(LD,  1, 0, 8'h22);
        step(LD,  1, 0, 8'h33);
        step(LD,  0, 1, 8'h0C);  chk("last_hold", dout, 8'h33);
        chk("last_lpv", {7'b0, low_packet_valid}, 8'h01);
        chk("last_pd_wait", {7'b0, parity_done}, 8'h00);
        step(FS,  0, 1, 8'h00);  chk("last_fs_pd", {7'b0, parity_done}, 8'h00);
        step(LAF, 0, 0, 8'h00);  chk("last_laf", dout, 8'h0C);
        chk("last_laf_pd", {7'b0, parity_done}, 8'h01);
        step(RIR, 0, 0, 8'h00);  chk("last_lpv_clr", {7'b0, low_packet_valid}, 8'h00);
        chk("last_err", {7'b0, err}, 8'h00);

        // Illegal address keeps the previous header
        step(DA,  1, 0, 8'h05);
        step(LFD, 1, 0, 8'h00);  chk("addr_legal", dout, 8'h05);
        step(DA,  1, 0, 8'h0F);
        step(LFD, 1, 0, 8'h00);  chk("addr_illegal", dout, 8'h05);

        // Reset mid-packet with flags set
        step(LD,  1, 0, 8'h11);
        step(LD,  0, 0, 8'hFF);
        step(IDLE, 0, 0, 8'h00);
        step(LD,  1, 0, 8'h22);  chk("mid_dout", dout, 8'h22);
        chk("mid_err", {7'b0, err}, 8'h01);
        #1 resetn = 1'b0;
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_pd", {7'b0, parity_done}, 8'h00);
        chk("arst_err", {7'b0, err}, 8'h00);
        chk("arst_lpv", {7'b0, low_packet_valid}, 8'h00);
        chk("arst_intpar", dut.int_parity, 8'h00);
        #1 resetn = 1'b1;
        step(LFD, 1, 0, 8'h00);  chk("arst_hdr", dout, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router. Sits between the input port and the FIFOs, directly downstream of router_fsm.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header, holds the byte arriving when the FIFO fills, and presents dout to the FIFO write port.
- Accumulates running parity and returns parity_done and low_packet_valid to the FSM. Flags err on parity mismatch.

Parameters:
WIDTH, 8, data byte width (header bits[1:0] = destination address, bits[WIDTH-1:2] = payload length)

Ports:
clock  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source byte valid; deasserted on the parity byte
data_in  input  WIDTH  source byte
fifo_full  input  1  selected FIFO full
detect_add  input  1  FSM in DECODE_ADDRESS
lfd_state  input  1  FSM in LOAD_FIRST_DATA
ld_state  input  1  FSM in LOAD_DATA
laf_state  input  1  FSM in LOAD_AFTER_FULL
full_state  input  1  FSM in FIFO_FULL_STATE
rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR; clears low_packet_valid
parity_done  output  1  parity byte has been loaded to dout
low_packet_valid  output  1  packet end (pkt_valid low) seen in LOAD_DATA
err  output  1  sticky parity mismatch for current packet
dout  output  WIDTH  byte to FIFO data input

Behaviour:
- Reset (resetn=0, async): dout, hdr, full_byte, int_parity and pkt_parity = 0; parity_done, low_packet_valid and err = 0.
- Header capture: on detect_add && pkt_valid && data_in[1:0]!=2'b11, hdr<=data_in. Address 2'b11 is ignored and hdr is held.
- dout, priority order:
  - lfd_state: dout<=hdr.
  - ld_state && !fifo_full: dout<=data_in.
  - laf_state: dout<=full_byte.
  - otherwise: hold.
- full_byte: on ld_state && fifo_full, full_byte<=data_in (byte arriving as FIFO fills; replayed in LOAD_AFTER_FULL).
- int_parity:
  - detect_add: 0.
  - elif lfd_state: int_parity^hdr.
  - elif ld_state && pkt_valid && !full_state: int_parity^data_in. This includes a byte diverted to full_byte.
  - The parity byte is never folded in.
- pkt_parity:
  - detect_add: 0.
  - ld_state && !pkt_valid: pkt_parity<=data_in.
- parity_done:
  - detect_add: 0.
  - Set on (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_packet_valid && !parity_done).
  - Otherwise hold.
- low_packet_valid: rst_int_reg has priority and clears to 0; else set on ld_state && !pkt_valid; else hold.
- err:
  - detect_add: 0.
  - elif parity_done && (int_parity != pkt_parity): 1.
  - Rises exactly one clock after parity_done rises; sticky until the next detect_add.
- Simultaneous events: detect_add clear beats any set. All strobes are one-hot from the FSM; behaviour under multiple strobes follows the priority order above.
- Reset mid-packet: all registers return to 0 immediately; the next packet starts clean at detect_add.
- Latency: dout is valid the cycle after its strobe; the FSM's write_enb_reg aligns with it.

Test Plan:
1. Reset: resetn=0 mid-packet with dout=8'h22 -> dout=0, parity_done=0, err=0, low_packet_valid=0 asynchronously, before the next edge.
2. Good packet, no full:
   - Stimulus: header 8'h0C, data 8'h11, 8'h22, 8'h33, parity 8'h0C.
   - dout sequence: 0C, 11, 22, 33, 0C.
   - parity_done=1 the cycle after the parity byte is seen in LOAD_DATA; err stays 0.
3. Bad parity: same packet with parity 8'hFF -> err=1 one clock after parity_done rises; err holds 1 until the next detect_add, then 0.
4. FIFO full mid-packet: fifo_full=1 during ld_state with data_in=8'h22 -> dout holds 8'h11; in laf_state dout=8'h22; final int_parity=8'h0C; err=0.
5. Full on last byte: fifo_full=1 when the parity byte 8'h0C arrives (pkt_valid=0) -> low_packet_valid=1; in laf_state dout=8'h0C and parity_done=1; rst_int_reg then clears low_packet_valid to 0.
6. Illegal address: header 8'h0F during detect_add -> hdr keeps its prior value, and lfd_state emits that prior value.
